truth_table_scanner: RTL
========================

# truth_table_scanner

Sequential stimulus/capture stage wrapped around the 5-input combinational decision block. On a `start` request it sweeps the block's 5-bit select/data input through all 32 codes, waits a settle interval per code, and samples the single-bit result. It assembles a 32-bit truth table, counts the ones, and compares the table against a programmed expected mask. Used as the self-check front end in front of the combinational stage and as the producer of its `i` vector.

## Interface
Parameters:
- `N_IN`, 5: width of the driven input vector; table width is 2**N_IN.
- `SETTLE`, 2: cycles held per code before sampling; legal range 1..15.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  scan request, sampled in IDLE only.
- `abort`  in  1  cancel an in-progress scan.
- `expected`  in  2**N_IN  golden truth table, captured on accepted `start`.
- `r_in`  in  1  result bit returned by the downstream combinational block.
- `vec_out`  out  N_IN  code driven to the downstream block's `i` input.
- `busy`  out  1  high from the cycle after `start` is accepted until scan end.
- `done`  out  1  one-cycle pulse when a full scan completes.
- `table_out`  out  2**N_IN  last completed truth table; bit k = result for code k.
- `ones_cnt`  out  N_IN+1  number of ones in `table_out`.
- `match`  out  1  `table_out == expected` for the last completed scan.

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - `vec_out`=0, `busy`=0.
  - On `start`=1: capture `expected`, clear the shadow table and running count, clear the settle counter, go to SETTLE.
- SETTLE:
  - Hold `vec_out`; increment the settle counter.
  - When the counter reaches SETTLE-1, go to SAMPLE.
- SAMPLE:
  - Write `shadow[vec_out] <= r_in`; add `r_in` to the running count.
  - If `vec_out` == 2**N_IN-1, go to DONE.
  - Otherwise increment `vec_out`, clear the settle counter, go to SETTLE.
- DONE:
  - Copy shadow to `table_out` and count to `ones_cnt`.
  - Register `match`; assert `done`; return to IDLE.
- `abort` in SETTLE or SAMPLE:
  - Next state is IDLE and `vec_out` returns to 0.
  - `table_out`, `ones_cnt` and `match` keep their previous values; no `done`.
  - `abort` takes priority over a same-cycle SAMPLE write.
- `start` while busy is ignored; `abort` in IDLE or DONE is ignored.
- Arithmetic:
  - `vec_out` never wraps, because the terminal code exits to DONE.
  - The count is N_IN+1 bits, so 32 ones fits without overflow.
- Reset, including mid-scan: state IDLE and every output 0 (`vec_out`, `busy`, `done`, `table_out`, `ones_cnt`, `match`); the captured expected mask is cleared.

## Timing
- `start` sampled high at edge E0: state is SETTLE and `busy`=1 after E0.
- Each code occupies SETTLE+1 cycles: SETTLE cycles in SETTLE plus 1 in SAMPLE.
- `done`, `table_out`, `ones_cnt` and `match` update together, 1 + 2**N_IN*(SETTLE+1) cycles after E0. Defaults give 97.
- `busy` falls in the same cycle `done` is high, so a new `start` is accepted the cycle after `done`.
- `r_in` must be valid SETTLE cycles after `vec_out` changes; the downstream block is combinational, so SETTLE=1 is sufficient in RTL simulation.

## Structure
- Shared package `tts_pkg` holds:
  - state enum (IDLE, SETTLE, SAMPLE, DONE);
  - localparam `SETTLE_W`=4;
  - function for the table width 2**N_IN.
- One natural sub-module: `tts_settle_timer`, a loadable down-counter with a terminal pulse, parameterised by `SETTLE_W`.
- The FSM, shadow table and ones accumulator stay in the top module.

## Test plan
- `r_in` tied to 1, `expected`=32'hFFFF_FFFF, `start` pulse:
  - `done` exactly 97 cycles later;
  - `table_out`=32'hFFFF_FFFF, `ones_cnt`=32, `match`=1.
- `r_in`=`vec_out[0]`, `expected`=32'h0000_0000:
  - `table_out`=32'hAAAA_AAAA, `ones_cnt`=16, `match`=0.
- Downstream combinational block instanced with a bench reference model; `expected` = model table:
  - `match`=1;
  - `vec_out` steps 0..31, each held 3 cycles.
- `abort` 40 cycles into the second scan:
  - `busy`=0 next cycle, no `done`;
  - `table_out` keeps the first scan's value;
  - re-`start` completes normally.
- `start` re-asserted every cycle during a scan: ignored, and `done` still lands at cycle 97.
- `rst_n` low mid-scan: all outputs 0 immediately (asynchronous); after release the FSM waits in IDLE for `start`.

Source files
------------

// File: rtl/tts_pkg.sv
// Shared types and helpers for the truth-table scanner.
package tts_pkg;

  // Width of the settle down-counter; holds SETTLE values up to 15.
  localparam int SETTLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } tts_state_t;

  // Number of truth-table entries for an n-input block.
  function automatic int table_w(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/tts_settle_timer.sv
// Loadable down-counter; tc flags the final enabled cycle of a settle window.
module tts_settle_timer
  import tts_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [SETTLE_W-1:0] load_val,
  input  logic                en,
  output logic                tc
);

  logic [SETTLE_W-1:0] count_q;
  logic [SETTLE_W-1:0] count_d;

  // Load wins over decrement; the counter parks at zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - SETTLE_W'(1);
    end
  end

  assign tc = en && (count_q == '0);

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/truth_table_scanner.sv
// Sweeps all input codes of a downstream combinational block, captures its
// truth table, counts ones and compares against a golden mask.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | vec_out=0, waiting for start
// SETTLE | holding vec_out while the downstream block settles
// SAMPLE | capturing r_in into the shadow table, advancing the code
// DONE   | publishing table, count and match; pulses done next cycle
module truth_table_scanner
  import tts_pkg::*;
#(
  parameter int N_IN   = 5,
  parameter int SETTLE = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [table_w(N_IN)-1:0] expected,
  input  logic                     r_in,
  output logic [N_IN-1:0]          vec_out,
  output logic                     busy,
  output logic                     done,
  output logic [table_w(N_IN)-1:0] table_out,
  output logic [N_IN:0]            ones_cnt,
  output logic                     match
);

  localparam int TW = table_w(N_IN);
  localparam int CW = N_IN + 1;
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE - 1);

  tts_state_t    state_q,  state_d;
  logic [N_IN-1:0] vec_q,  vec_d;
  logic [TW-1:0] shadow_q, shadow_d;
  logic [TW-1:0] exp_q,    exp_d;
  logic [CW-1:0] cnt_q,    cnt_d;
  logic [TW-1:0] table_q,  table_d;
  logic [CW-1:0] ones_q,   ones_d;
  logic          match_q,  match_d;
  logic          done_q,   done_d;

  logic tmr_load;
  logic tmr_en;
  logic tmr_tc;

  tts_settle_timer u_settle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (SETTLE_LOAD),
    .en       (tmr_en),
    .tc       (tmr_tc)
  );

  // Next-state, datapath updates and timer control.
  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    shadow_d = shadow_q;
    exp_d    = exp_q;
    cnt_d    = cnt_q;
    table_d  = table_q;
    ones_d   = ones_q;
    match_d  = match_q;
    done_d   = 1'b0;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        vec_d = '0;
        if (start) begin
          exp_d    = expected;
          shadow_d = '0;
          cnt_d    = '0;
          tmr_load = 1'b1;
          state_d  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          vec_d   = '0;
          state_d = ST_IDLE;
        end else begin
          tmr_en = 1'b1;
          if (tmr_tc) begin
            state_d = ST_SAMPLE;
          end
        end
      end
      ST_SAMPLE: begin
        // Abort suppresses the write so a cancelled scan leaves no trace.
        if (abort) begin
          vec_d   = '0;
          state_d = ST_IDLE;
        end else begin
          shadow_d[vec_q] = r_in;
          cnt_d           = cnt_q + CW'(r_in);
          if (&vec_q) begin
            state_d = ST_DONE;
          end else begin
            vec_d    = vec_q + N_IN'(1);
            tmr_load = 1'b1;
            state_d  = ST_SETTLE;
          end
        end
      end
      ST_DONE: begin
        table_d = shadow_q;
        ones_d  = cnt_q;
        match_d = (shadow_q == exp_q);
        done_d  = 1'b1;
        vec_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        vec_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      vec_q    <= '0;
      shadow_q <= '0;
      exp_q    <= '0;
      cnt_q    <= '0;
      table_q  <= '0;
      ones_q   <= '0;
      match_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      shadow_q <= shadow_d;
      exp_q    <= exp_d;
      cnt_q    <= cnt_d;
      table_q  <= table_d;
      ones_q   <= ones_d;
      match_q  <= match_d;
      done_q   <= done_d;
    end
  end

  // busy drops as DONE hands over to IDLE, the same cycle done is high.
  assign busy      = (state_q != ST_IDLE);
  assign vec_out   = vec_q;
  assign done      = done_q;
  assign table_out = table_q;
  assign ones_cnt  = ones_q;
  assign match     = match_q;

endmodule
